// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number game controller.
// Imported by the controller top and the A/B scorer.
package guess_pkg;

  typedef enum logic [1:0] {
    Q_ENTRY = 2'd0,
    A_ENTRY = 2'd1,
    EVAL    = 2'd2,
    RESULT  = 2'd3
  } fsm_t;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_GOOD = 2'd1;
  localparam logic [1:0] ST_BAD  = 2'd2;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef logic [3:0][3:0] digits_t;

  // Only the first n slots of the current entry count as filled.
  function automatic logic is_dup(
    digits_t    v,
    logic [1:0] n,
    logic [3:0] d
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n) && v[i] == d) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/guess_controller_if.sv
// Keypad strobe bundle feeding the guess controller.
// The keypad side drives, the controller samples.
interface guess_controller_if;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (
    output key_valid,
    output key_code
  );

  modport slave (
    input key_valid,
    input key_code
  );
endinterface

// File: rtl/guess_controller_ab_scorer.sv
// Combinational A/B scorer for a 4-digit guess.
// A: same digit, same slot; B: same digit, other slot.
module ab_scorer
  import guess_pkg::*;
(
  input  digits_t    secret,
  input  digits_t    guess,
  output logic [2:0] a_count,
  output logic [2:0] b_count
);

  always_comb begin
    a_count = '0;
    b_count = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (guess[i] == secret[j]) begin
          if (i == j) a_count = a_count + 3'd1;
          else        b_count = b_count + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/guess_controller.sv
// Guess-number game controller: secret/guess entry,
// scoring, and timed result display handshake.
module guess_controller
  import guess_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 10
) (
  input  logic               clk_div,
  input  logic               reset,
  guess_controller_if.slave  key,
  output logic               match,
  output logic [1:0]         digit_state,
  output logic               qa_state,
  output logic [1:0]         state,
  output logic [2:0]         a_count,
  output logic [2:0]         b_count,
  output logic [3:0]         tries,
  output logic               reject
);

  fsm_t              fsm_q, fsm_d;
  digits_t           secret_q, secret_d;
  digits_t           guess_q, guess_d;
  logic [1:0]        dig_q, dig_d;
  logic [2:0]        a_q, a_d;
  logic [2:0]        b_q, b_d;
  logic [3:0]        tries_q, tries_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        st_q, st_d;
  logic              rej_q, rej_d;

  logic [2:0] sc_a, sc_b;
  logic       is_digit, is_clear, dup;
  digits_t    cur;

  ab_scorer u_scorer (
    .secret  (secret_q),
    .guess   (guess_q),
    .a_count (sc_a),
    .b_count (sc_b)
  );

  assign is_digit = key.key_valid &&
                    key.key_code <= DIGIT_MAX;
  assign is_clear = key.key_valid &&
                    key.key_code == KEY_CLEAR;
  assign cur = (fsm_q == Q_ENTRY) ? secret_q
                                  : guess_q;
  assign dup = is_dup(cur, dig_q, key.key_code);

  always_ff @(posedge clk_div) begin
    if (reset) begin
      fsm_q    <= Q_ENTRY;
      secret_q <= '0;
      guess_q  <= '0;
      dig_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tries_q  <= '0;
      hold_q   <= '0;
      st_q     <= ST_NONE;
      rej_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      dig_q    <= dig_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tries_q  <= tries_d;
      hold_q   <= hold_d;
      st_q     <= st_d;
      rej_q    <= rej_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    dig_d    = dig_q;
    a_d      = a_q;
    b_d      = b_q;
    tries_d  = tries_q;
    hold_d   = hold_q;
    st_d     = st_q;
    rej_d    = 1'b0;

    unique case (fsm_q)
      Q_ENTRY, A_ENTRY: begin
        unique case (1'b1)
          is_clear: dig_d = '0;
          is_digit && dup: rej_d = 1'b1;
          is_digit && !dup: begin
            if (fsm_q == Q_ENTRY)
              secret_d[dig_q] = key.key_code;
            else
              guess_d[dig_q] = key.key_code;
            if (dig_q == 2'd3) begin
              dig_d = '0;
              if (fsm_q == Q_ENTRY) begin
                fsm_d   = A_ENTRY;
                tries_d = '0;
              end else begin
                fsm_d = EVAL;
              end
            end else begin
              dig_d = dig_q + 2'd1;
            end
          end
          default: ;
        endcase
      end

      EVAL: begin
        a_d     = sc_a;
        b_d     = sc_b;
        tries_d = (tries_q == 4'd15) ? tries_q
                                     : tries_q + 4'd1;
        hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        st_d    = (sc_a == 3'd4) ? ST_GOOD : ST_BAD;
        fsm_d   = RESULT;
      end

      RESULT: begin
        if (hold_q == '0) begin
          st_d  = ST_NONE;
          dig_d = '0;
          fsm_d = (st_q == ST_GOOD) ? Q_ENTRY
                                    : A_ENTRY;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: fsm_d = Q_ENTRY;
    endcase
  end

  assign match       = (fsm_q == RESULT);
  assign qa_state    = (fsm_q != Q_ENTRY);
  assign digit_state = dig_q;
  assign state       = st_q;
  assign a_count     = a_q;
  assign b_count     = b_q;
  assign tries       = tries_q;
  assign reject      = rej_q;

endmodule

// File: tb/tb_guess_controller.sv
// Scoreboard bench for guess_controller with a short hold.
// Expected scores are queued at guess entry, popped on match.
module tb_guess_controller;
  import guess_pkg::*;

  localparam int HOLD = 8;

  logic       clk_div = 1'b0;
  logic       reset;
  logic       match;
  logic [1:0] digit_state;
  logic       qa_state;
  logic [1:0] state;
  logic [2:0] a_count;
  logic [2:0] b_count;
  logic [3:0] tries;
  logic       reject;

  guess_controller_if kif();

  guess_controller #(
    .HOLD_CYCLES (HOLD),
    .HOLD_W      (4)
  ) dut (
    .clk_div     (clk_div),
    .reset       (reset),
    .key         (kif.slave),
    .match       (match),
    .digit_state (digit_state),
    .qa_state    (qa_state),
    .state       (state),
    .a_count     (a_count),
    .b_count     (b_count),
    .tries       (tries),
    .reject      (reject)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int a;
    int b;
    int st;
    int tries;
  } exp_t;

  exp_t sb[$];
  int   sec_m[4];
  int   gue_m[4];
  int   tries_m;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk_div);
    kif.key_valid = 1'b1;
    kif.key_code  = k;
    @(negedge clk_div);
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
  endtask

  task automatic enter_secret(input int d0, d1, d2, d3);
    press(4'(d0));
    press(4'(d1));
    press(4'(d2));
    press(4'(d3));
    sec_m   = '{d0, d1, d2, d3};
    tries_m = 0;
    check("qa_after_secret", int'(qa_state), 1);
    check("dig_after_secret", int'(digit_state), 0);
  endtask

  // Model: B is the count of shared digits minus A.
  task automatic enter_guess(input int g0, g1, g2, g3);
    exp_t e;
    int   common;
    press(4'(g0));
    press(4'(g1));
    press(4'(g2));
    press(4'(g3));
    gue_m  = '{g0, g1, g2, g3};
    e.a    = 0;
    common = 0;
    for (int i = 0; i < 4; i++) begin
      if (gue_m[i] == sec_m[i]) e.a++;
      if (gue_m[i] inside {sec_m}) common++;
    end
    e.b     = common - e.a;
    e.st    = (e.a == 4) ? 1 : 2;
    tries_m = (tries_m < 15) ? tries_m + 1 : 15;
    e.tries = tries_m;
    sb.push_back(e);
    check("match_in_eval", int'(match), 0);
    kif.key_valid = 1'b1;
    kif.key_code  = 4'd9;
  endtask

  task automatic wait_result();
    exp_t e;
    int   cnt   = 0;
    int   guard = 0;
    int   good;
    @(negedge clk_div);
    check("match_rise", int'(match), 1);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      good = 0;
    end else begin
      e = sb.pop_front();
      check("a_count", int'(a_count), e.a);
      check("b_count", int'(b_count), e.b);
      check("state", int'(state), e.st);
      check("tries", int'(tries), e.tries);
      good = (e.st == 1) ? 1 : 0;
    end
    while (match && guard < 100) begin
      cnt++;
      check("dig_in_result", int'(digit_state), 0);
      kif.key_valid = 1'b1;
      kif.key_code  = 4'(cnt % 10);
      @(negedge clk_div);
      guard++;
    end
    kif.key_valid = 1'b0;
    check("hold_len", cnt, HOLD);
    check("qa_after_hold", int'(qa_state), good ? 0 : 1);
    check("dig_after_hold", int'(digit_state), 0);
    check("state_after_hold", int'(state), 0);
  endtask

  initial begin
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    reset   = 1'b1;
    tries_m = 0;
    @(negedge clk_div);
    @(negedge clk_div);
    reset = 1'b0;
    check("rst_match", int'(match), 0);
    check("rst_dig", int'(digit_state), 0);
    check("rst_qa", int'(qa_state), 0);
    check("rst_state", int'(state), 0);
    check("rst_a", int'(a_count), 0);
    check("rst_b", int'(b_count), 0);
    check("rst_tries", int'(tries), 0);
    check("rst_reject", int'(reject), 0);

    enter_secret(1, 2, 3, 4);
    enter_guess(1, 2, 3, 4);
    wait_result();

    enter_secret(1, 2, 3, 4);
    enter_guess(4, 3, 2, 1);
    wait_result();
    enter_guess(1, 2, 4, 3);
    wait_result();
    enter_guess(1, 2, 3, 4);
    wait_result();

    press(4'd5);
    press(4'd5);
    check("reject_pulse", int'(reject), 1);
    check("dig_after_dup", int'(digit_state), 1);
    @(negedge clk_div);
    check("reject_clear", int'(reject), 0);
    press(4'd6);
    check("dig_after_6", int'(digit_state), 2);
    press(4'hC);
    press(4'hF);
    check("dig_after_ign", int'(digit_state), 2);
    check("reject_ign", int'(reject), 0);
    press(4'd7);
    press(4'd8);
    sec_m   = '{5, 6, 7, 8};
    tries_m = 0;
    check("qa_after_5678", int'(qa_state), 1);

    press(4'd7);
    press(4'd8);
    check("dig_before_clr", int'(digit_state), 2);
    press(KEY_CLEAR);
    check("dig_after_clr", int'(digit_state), 0);
    check("qa_after_clr", int'(qa_state), 1);
    press(KEY_CLEAR);
    check("dig_clr_idle", int'(digit_state), 0);
    enter_guess(9, 0, 1, 2);
    wait_result();

    enter_guess(5, 6, 7, 8);
    kif.key_valid = 1'b0;
    @(negedge clk_div);
    check("match_pre_abort", int'(match), 1);
    repeat (3) @(negedge clk_div);
    reset = 1'b1;
    @(negedge clk_div);
    reset = 1'b0;
    sb.delete();
    check("abort_match", int'(match), 0);
    check("abort_state", int'(state), 0);
    check("abort_qa", int'(qa_state), 0);
    check("abort_tries", int'(tries), 0);
    check("abort_dig", int'(digit_state), 0);

    enter_secret(0, 9, 8, 7);
    enter_guess(0, 9, 7, 8);
    wait_result();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
